pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 29 ++
 rtl/pipe_fwd_sel.sv | 44 ++++
 rtl/pipe_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   state_t : controller FSM state (RUN, DRAIN, HALTED)
//   slot_t  : one tracked post-ID pipeline entry {valid, wreg, rmem, rd}
//   FWD_RF  : forward-select code meaning "take the register file value"
// Register addresses are stored zero-extended to RD_MAX bits so that one
// struct type serves every AW; AW must not exceed RD_MAX.
package pipe_ctrl_pkg;

  localparam int FWD_RF = 0;
  localparam int RD_MAX = 8;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic              valid;
    logic              wreg;
    logic              rmem;
    logic [RD_MAX-1:0] rd;
  } slot_t;

  function automatic slot_t empty_slot();
    return '0;
  endfunction

endpackage

// File: rtl/pipe_fwd_sel.sv
// Forwarding selector for one source operand.
// Scans the tracked slots for the youngest producer of src and reports
// where to forward from, plus whether that producer is a load whose data
// is not yet available (load-use hazard).
// Ports:
//   slots       in  tracked pipeline entries, index 0 = youngest (EX)
//   src         in  source register address
//   use_src     in  the instruction actually reads src
//   fwd         out FWD_RF when no producer, else slot index + 1
//   load_hazard out selected producer is a load in a slot below LOAD_STAGE
module pipe_fwd_sel
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES     = 3,
  parameter int AW         = 5,
  parameter int LOAD_STAGE = 1,
  parameter int FW         = $clog2(STAGES + 1)
) (
  input  slot_t           slots [STAGES],
  input  logic [AW-1:0]   src,
  input  logic            use_src,
  output logic [FW-1:0]   fwd,
  output logic            load_hazard
);

  logic [RD_MAX-1:0] src_ext;

  assign src_ext = RD_MAX'(src);

  // Walk from the oldest slot to the youngest so the last hit wins; that
  // gives the youngest producer priority. Register 0 never matches.
  always_comb begin
    fwd         = FW'(FWD_RF);
    load_hazard = 1'b0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (use_src && slots[k].valid && slots[k].wreg &&
          (slots[k].rd == src_ext) && (slots[k].rd != '0)) begin
        fwd         = FW'(k + 1);
        load_hazard = slots[k].rmem && (k < LOAD_STAGE);
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: tracks post-ID slots, selects operand
// forwarding, raises load-use stalls, freezes on memory back-pressure,
// squashes IF/ID on redirects and drains the pipe on a halt instruction.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   id_*                    instruction currently in ID
//   br_taken                ID resolved a redirect
//   mem_busy                memory stage not ready (freezes everything)
//   fwd_a, fwd_b            forward selects for rs / rt (0 = register file)
//   stall_front, bubble_ex  hold PC+IF/ID, insert bubble into EX
//   freeze, flush_ifid      hold all pipeline registers, squash IF/ID
//   stage_valid             valid bit per slot (bit k = slot k)
//   halted, retired         halt reached, retired-instruction count
//   dbg_state               current FSM state
//
// ID acceptance: the instruction in ID is taken into slot 0 on a rising
// edge where id_valid=1 and stall_front=0 (stall_front covers freeze,
// load-use and non-RUN states). While stall_front=1, ID must hold its
// fields, including br_taken, stable until accepted.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STAGES     = 3,
  parameter int AW         = 5,
  parameter int LOAD_STAGE = 1,
  parameter int RCW        = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          id_valid,
  input  logic [AW-1:0]                 id_rs,
  input  logic [AW-1:0]                 id_rt,
  input  logic                          id_use_rs,
  input  logic                          id_use_rt,
  input  logic [AW-1:0]                 id_rd,
  input  logic                          id_wreg,
  input  logic                          id_rmem,
  input  logic                          id_halt,
  input  logic                          br_taken,
  input  logic                          mem_busy,
  output logic [$clog2(STAGES+1)-1:0]   fwd_a,
  output logic [$clog2(STAGES+1)-1:0]   fwd_b,
  output logic                          stall_front,
  output logic                          bubble_ex,
  output logic                          freeze,
  output logic                          flush_ifid,
  output logic [STAGES-1:0]             stage_valid,
  output logic                          halted,
  output logic [RCW-1:0]                retired,
  output state_t                        dbg_state
);

  localparam int FW = $clog2(STAGES + 1);

  slot_t             slots [STAGES];
  state_t            state;
  state_t            state_nxt;
  logic [RCW-1:0]    retired_q;
  logic [STAGES-1:0] valid_vec;

  logic [FW-1:0]     fwd_a_raw;
  logic [FW-1:0]     fwd_b_raw;
  logic              haz_a;
  logic              haz_b;

  logic              hazard;
  logic              stall_int;
  logic              accept;
  logic              load_slot0;
  slot_t             id_entry;

  pipe_fwd_sel #(
    .STAGES     (STAGES),
    .AW         (AW),
    .LOAD_STAGE (LOAD_STAGE),
    .FW         (FW)
  ) u_sel_a (
    .slots       (slots),
    .src         (id_rs),
    .use_src     (id_use_rs),
    .fwd         (fwd_a_raw),
    .load_hazard (haz_a)
  );

  pipe_fwd_sel #(
    .STAGES     (STAGES),
    .AW         (AW),
    .LOAD_STAGE (LOAD_STAGE),
    .FW         (FW)
  ) u_sel_b (
    .slots       (slots),
    .src         (id_rt),
    .use_src     (id_use_rt),
    .fwd         (fwd_b_raw),
    .load_hazard (haz_b)
  );

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      valid_vec[k] = slots[k].valid;
    end
  end

  // Internal (ungated) control. Freeze dominates: it holds everything, so
  // the load-use bubble is only inserted on a non-frozen cycle.
  always_comb begin
    hazard     = haz_a | haz_b;
    stall_int  = mem_busy | hazard | (state != RUN);
    accept     = id_valid & ~stall_int;
    load_slot0 = accept & ~id_halt;
    id_entry   = empty_slot();
    if (load_slot0) begin
      id_entry.valid = 1'b1;
      id_entry.wreg  = id_wreg;
      id_entry.rmem  = id_rmem;
      id_entry.rd    = RD_MAX'(id_rd);
    end
  end

  // All externally visible combinational outputs read 0 during reset.
  always_comb begin
    fwd_a       = '0;
    fwd_b       = '0;
    stall_front = 1'b0;
    bubble_ex   = 1'b0;
    freeze      = 1'b0;
    flush_ifid  = 1'b0;
    stage_valid = '0;
    halted      = 1'b0;
    if (!reset) begin
      fwd_a       = fwd_a_raw;
      fwd_b       = fwd_b_raw;
      stall_front = stall_int;
      bubble_ex   = ~mem_busy & hazard;
      freeze      = mem_busy;
      flush_ifid  = br_taken & ~stall_int;
      stage_valid = valid_vec;
      halted      = (state == HALTED);
    end
  end

  assign retired   = retired_q;
  assign dbg_state = state;

  // FSM next state; frozen cycles hold the current state.
  always_comb begin
    state_nxt = state;
    if (!mem_busy) begin
      case (state)
        RUN:     if (accept && id_halt) state_nxt = DRAIN;
        DRAIN:   if (valid_vec == '0)   state_nxt = HALTED;
        HALTED:  state_nxt = HALTED;
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Slot shift register and retire counter; both hold while frozen.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        slots[k] <= empty_slot();
      end
      retired_q <= '0;
    end else if (!mem_busy) begin
      slots[0] <= id_entry;
      for (int k = 1; k < STAGES; k++) begin
        slots[k] <= slots[k-1];
      end
      if (slots[STAGES-1].valid) begin
        retired_q <= retired_q + RCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl. A second instance with a
// 4-bit retire counter shares the stimulus to exercise counter wrap.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_use_rs, id_use_rt, id_wreg, id_rmem, id_halt;
  logic        br_taken, mem_busy;

  logic [1:0]  fwd_a, fwd_b;
  logic        stall_front, bubble_ex, freeze, flush_ifid, halted;
  logic [2:0]  stage_valid;
  logic [15:0] retired;
  state_t      dbg_state;

  logic [1:0]  w_fwd_a, w_fwd_b;
  logic        w_stall_front, w_bubble_ex, w_freeze, w_flush_ifid, w_halted;
  logic [2:0]  w_stage_valid;
  logic [3:0]  w_retired;
  state_t      w_dbg_state;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  pipe_ctrl dut (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_wreg(id_wreg),
    .id_rmem(id_rmem), .id_halt(id_halt), .br_taken(br_taken), .mem_busy(mem_busy),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_front(stall_front), .bubble_ex(bubble_ex),
    .freeze(freeze), .flush_ifid(flush_ifid), .stage_valid(stage_valid),
    .halted(halted), .retired(retired), .dbg_state(dbg_state)
  );

  pipe_ctrl #(.RCW(4)) dut_w (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_wreg(id_wreg),
    .id_rmem(id_rmem), .id_halt(id_halt), .br_taken(br_taken), .mem_busy(mem_busy),
    .fwd_a(w_fwd_a), .fwd_b(w_fwd_b), .stall_front(w_stall_front), .bubble_ex(w_bubble_ex),
    .freeze(w_freeze), .flush_ifid(w_flush_ifid), .stage_valid(w_stage_valid),
    .halted(w_halted), .retired(w_retired), .dbg_state(w_dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic urs,
                        input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                        input logic wreg, input logic rmem, input logic halt);
    id_valid  = v;
    id_rs     = rs;
    id_use_rs = urs;
    id_rt     = rt;
    id_use_rt = urt;
    id_rd     = rd;
    id_wreg   = wreg;
    id_rmem   = rmem;
    id_halt   = halt;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    br_taken = 1'b0;
    mem_busy = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    set_id(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
    br_taken = 1'b1;
    mem_busy = 1'b1;
    tick();
    checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL rst_freeze: got %b want 0", freeze); end
    checks++; if (stall_front !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall_front); end
    checks++; if (flush_ifid !== 1'b0) begin errors++; $display("FAIL rst_flush: got %b want 0", flush_ifid); end
    checks++; if (stage_valid !== 3'b000) begin errors++; $display("FAIL rst_valid: got %b want 000", stage_valid); end
    checks++; if (retired !== 16'd0) begin errors++; $display("FAIL rst_retired: got %0d want 0", retired); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b want 0", halted); end
    reset = 1'b0;
    idle();
    #1;
    checks++; if (dbg_state !== RUN) begin errors++; $display("FAIL rst_state: got %0d want %0d", dbg_state, RUN); end
  endtask

  task automatic test_fwd();
    test_reset();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    // slot0: rd=3 writer
    set_id(1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (fwd_a !== 2'd1) begin errors++; $display("FAIL fwd_ex: got %0d want 1", fwd_a); end
    checks++; if (fwd_b !== 2'd0) begin errors++; $display("FAIL fwd_unused: got %0d want 0", fwd_b); end
    checks++; if (stall_front !== 1'b0) begin errors++; $display("FAIL fwd_nostall: got %b want 0", stall_front); end
    tick();
    // slot0 rd=3, slot1 rd=3
    set_id(1'b1, 5'd3, 1'b1, 5'd9, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (fwd_a !== 2'd1) begin errors++; $display("FAIL fwd_youngest: got %0d want 1", fwd_a); end
    checks++; if (fwd_b !== 2'd0) begin errors++; $display("FAIL fwd_nomatch: got %0d want 0", fwd_b); end
    tick();
    // slot0 rd=0 writer, slot1 rd=3, slot2 rd=3
    set_id(1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (fwd_a !== 2'd0) begin errors++; $display("FAIL fwd_r0: got %0d want 0", fwd_a); end
    checks++; if (fwd_b !== 2'd2) begin errors++; $display("FAIL fwd_mem: got %0d want 2", fwd_b); end
    tick();
    // slot0 rd=7 no write, slot1 rd=0, slot2 rd=3
    set_id(1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (fwd_a !== 2'd3) begin errors++; $display("FAIL fwd_wb: got %0d want 3", fwd_a); end
    checks++; if (fwd_b !== 2'd0) begin errors++; $display("FAIL fwd_nowreg: got %0d want 0", fwd_b); end
    tick();
    idle();
  endtask

  task automatic test_load_use();
    test_reset();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
    #1;
    checks++; if (stall_front !== 1'b1) begin errors++; $display("FAIL lu_stall: got %b want 1", stall_front); end
    checks++; if (bubble_ex !== 1'b1) begin errors++; $display("FAIL lu_bubble: got %b want 1", bubble_ex); end
    tick();
    checks++; if (stage_valid !== 3'b010) begin errors++; $display("FAIL lu_slots: got %b want 010", stage_valid); end
    checks++; if (stall_front !== 1'b0) begin errors++; $display("FAIL lu_release: got %b want 0", stall_front); end
    checks++; if (bubble_ex !== 1'b0) begin errors++; $display("FAIL lu_nobubble: got %b want 0", bubble_ex); end
    checks++; if (fwd_b !== 2'd2) begin errors++; $display("FAIL lu_fwd: got %0d want 2", fwd_b); end
    tick();
    checks++; if (stage_valid !== 3'b101) begin errors++; $display("FAIL lu_accept: got %b want 101", stage_valid); end
    idle();
  endtask

  task automatic test_branch_stall();
    test_reset();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    br_taken = 1'b1;
    #1;
    checks++; if (flush_ifid !== 1'b0) begin errors++; $display("FAIL br_stalled: got %b want 0", flush_ifid); end
    tick();
    checks++; if (flush_ifid !== 1'b1) begin errors++; $display("FAIL br_flush: got %b want 1", flush_ifid); end
    idle();
    tick();
  endtask

  task automatic test_freeze();
    test_reset();
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(10 + i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b0, 1'b0, 1'b0);
    mem_busy = 1'b1;
    br_taken = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL frz_on%0d: got %b want 1", c, freeze); end
      checks++; if ({stall_front, bubble_ex, flush_ifid} !== 3'b100) begin errors++; $display("FAIL frz_ctl%0d: got %b want 100", c, {stall_front, bubble_ex, flush_ifid}); end
      checks++; if (stage_valid !== 3'b111) begin errors++; $display("FAIL frz_valid%0d: got %b want 111", c, stage_valid); end
      checks++; if (retired !== 16'd0) begin errors++; $display("FAIL frz_ret%0d: got %0d want 0", c, retired); end
      tick();
    end
    mem_busy = 1'b0;
    #1;
    checks++; if ({freeze, stall_front, flush_ifid} !== 3'b001) begin errors++; $display("FAIL frz_resume: got %b want 001", {freeze, stall_front, flush_ifid}); end
    tick();
    checks++; if (retired !== 16'd1) begin errors++; $display("FAIL frz_ret_after: got %0d want 1", retired); end
    checks++; if (stage_valid !== 3'b111) begin errors++; $display("FAIL frz_valid_after: got %b want 111", stage_valid); end
    idle();
  endtask

  task automatic test_halt();
    logic [2:0]  exp_sv  [3];
    logic [15:0] exp_ret [3];
    exp_sv  = '{3'b110, 3'b100, 3'b000};
    exp_ret = '{16'd1, 16'd2, 16'd3};
    test_reset();
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(1 + i), 1'b1, 1'b0, 1'b0);
      tick();
    end
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    #1;
    checks++; if (stall_front !== 1'b0) begin errors++; $display("FAIL halt_accept: got %b want 0", stall_front); end
    tick();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    for (int d = 0; d < 3; d++) begin
      checks++; if (dbg_state !== DRAIN) begin errors++; $display("FAIL drain_state%0d: got %0d want %0d", d, dbg_state, DRAIN); end
      checks++; if ({stall_front, halted} !== 2'b10) begin errors++; $display("FAIL drain_ctl%0d: got %b want 10", d, {stall_front, halted}); end
      checks++; if (stage_valid !== exp_sv[d]) begin errors++; $display("FAIL drain_valid%0d: got %b want %b", d, stage_valid, exp_sv[d]); end
      checks++; if (retired !== exp_ret[d]) begin errors++; $display("FAIL drain_ret%0d: got %0d want %0d", d, retired, exp_ret[d]); end
      tick();
    end
    checks++; if ({halted, stall_front} !== 2'b11) begin errors++; $display("FAIL halted: got %b want 11", {halted, stall_front}); end
    tick();
    checks++; if ({halted, stage_valid} !== 4'b1000) begin errors++; $display("FAIL halted_hold: got %b want 1000", {halted, stage_valid}); end
    checks++; if (retired !== 16'd3) begin errors++; $display("FAIL halt_ret: got %0d want 3", retired); end
    test_reset();
    checks++; if ({halted, stall_front} !== 2'b00) begin errors++; $display("FAIL halt_cleared: got %b want 00", {halted, stall_front}); end
    idle();
  endtask

  task automatic test_wrap();
    test_reset();
    for (int i = 0; i < 17; i++) begin
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    idle();
    for (int i = 0; i < 3; i++) tick();
    checks++; if (retired !== 16'd17) begin errors++; $display("FAIL wrap_ret16: got %0d want 17", retired); end
    checks++; if (w_retired !== 4'd1) begin errors++; $display("FAIL wrap_ret4: got %0d want 1", w_retired); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle();
    test_reset();
    test_fwd();
    test_load_use();
    test_branch_stall();
    test_freeze();
    test_halt();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
